// File: rtl/onehot_scan_decoder_pkg.sv
// Shared types for the one-hot scan decoder.
//   mode_e  : operating mode, sampled from the mode input only when start is high
//   state_e : control FSM states
package onehot_scan_decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_OFF       = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_SCAN = 2'b10
  } state_e;

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// Control/status bundle for onehot_scan_decoder.
//   start, stop, load, mode, sel : commands from the controlling side (master)
//   out, out_idx, valid, wrap    : registered decoder outputs (slave)
interface onehot_scan_decoder_if #(
  parameter int unsigned SEL_W = 3
);
  localparam int unsigned OUT_W = 2 ** SEL_W;

  logic             start;
  logic             stop;
  logic             load;
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] out_idx;
  logic             valid;
  logic             wrap;

  modport master (
    output start, stop, load, mode, sel,
    input  out, out_idx, valid, wrap
  );

  modport slave (
    input  start, stop, load, mode, sel,
    output out, out_idx, valid, wrap
  );
endinterface

// File: rtl/onehot_scan_decoder_dec.sv
// Pure combinational binary-to-one-hot decoder.
//   idx    : binary index, SEL_W bits
//   onehot : 2**SEL_W lines, exactly bit idx set
module onehot_dec #(
  parameter int unsigned SEL_W = 3
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [2**SEL_W-1:0]   onehot
);
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a direct/scan control FSM.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : command inputs (start/stop/load/mode/sel) and registered
//           outputs (out/out_idx/valid/wrap)
// DIRECT holds one line; SCAN_UP/SCAN_DOWN advance the line every DWELL cycles.
module onehot_scan_decoder
  import onehot_scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onehot_scan_decoder_if.slave  bus
);
  localparam int unsigned OUT_W = 2 ** SEL_W;
  localparam int unsigned CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             down_q, down_d;
  logic             wrap_q, wrap_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] dec_onehot;

  // Decode the next index so the one-hot output is registered alongside it.
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx    (idx_d),
    .onehot (dec_onehot)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    down_d  = down_q;
    wrap_d  = 1'b0;

    if (bus.stop) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (bus.start) begin
      cnt_d = '0;
      unique case (mode_e'(bus.mode))
        MODE_DIRECT: begin
          state_d = ST_HOLD;
          idx_d   = bus.sel;
        end
        MODE_SCAN_UP: begin
          state_d = ST_SCAN;
          idx_d   = bus.sel;
          down_d  = 1'b0;
        end
        MODE_SCAN_DOWN: begin
          state_d = ST_SCAN;
          idx_d   = bus.sel;
          down_d  = 1'b1;
        end
        // OFF from HOLD/SCAN switches the outputs off, same as from IDLE.
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (bus.load) idx_d = bus.sel;
        end
        ST_SCAN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (down_q) begin
              idx_d  = idx_q - SEL_W'(1);
              wrap_d = (idx_q == '0);
            end else begin
              idx_d  = idx_q + SEL_W'(1);
              wrap_d = (idx_q == '1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    valid_d = (state_d != ST_IDLE);
    out_d   = valid_d ? dec_onehot : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      down_q  <= 1'b0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      down_q  <= down_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.out_idx = idx_q;
  assign bus.valid   = valid_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench: three builds (SEL_W=3/DWELL=4, SEL_W=3/DWELL=1, SEL_W=4/DWELL=2).
module tb_onehot_scan_decoder;
  import onehot_scan_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder_if #(.SEL_W(3)) b0 ();
  onehot_scan_decoder_if #(.SEL_W(3)) b1 ();
  onehot_scan_decoder_if #(.SEL_W(4)) b2 ();

  onehot_scan_decoder #(.SEL_W(3), .DWELL(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  onehot_scan_decoder #(.SEL_W(3), .DWELL(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  onehot_scan_decoder #(.SEL_W(4), .DWELL(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned wraps;
    rst_n = 1'b0;
    {b0.start, b0.stop, b0.load} = '0; b0.mode = 2'b00; b0.sel = '0;
    {b1.start, b1.stop, b1.load} = '0; b1.mode = 2'b00; b1.sel = '0;
    {b2.start, b2.stop, b2.load} = '0; b2.mode = 2'b00; b2.sel = '0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_out",   32'(b0.out),     32'h0);
    check("rst_valid", 32'(b0.valid),   32'h0);

    // Reset mid-scan, with start asserted in the same cycle.
    b0.start = 1'b1; b0.mode = MODE_SCAN_UP; b0.sel = 3'd7;
    tick();
    b0.start = 1'b0;
    tick(); tick(); tick(); tick();
    check("pre_rst_wrap", 32'(b0.wrap), 32'h1);
    rst_n = 1'b0; b0.start = 1'b1; b0.sel = 3'd5;
    tick();
    rst_n = 1'b1; b0.start = 1'b0;
    check("midrst_out",   32'(b0.out),     32'h0);
    check("midrst_valid", 32'(b0.valid),   32'h0);
    check("midrst_idx",   32'(b0.out_idx), 32'h0);
    check("midrst_wrap",  32'(b0.wrap),    32'h0);

    // DIRECT / load / stop.
    b0.start = 1'b1; b0.mode = MODE_DIRECT; b0.sel = 3'd5;
    tick();
    b0.start = 1'b0;
    check("direct_out",   32'(b0.out),     32'h20);
    check("direct_valid", 32'(b0.valid),   32'h1);
    check("direct_idx",   32'(b0.out_idx), 32'h5);
    b0.load = 1'b1; b0.sel = 3'd2;
    tick();
    b0.load = 1'b0;
    check("load_out", 32'(b0.out), 32'h04);
    check("load_idx", 32'(b0.out_idx), 32'h2);
    b0.stop = 1'b1;
    tick();
    b0.stop = 1'b0;
    check("stop_out",   32'(b0.out),   32'h00);
    check("stop_valid", 32'(b0.valid), 32'h0);

    // SCAN_UP from 6 with DWELL=4; mode input wiggles without start.
    b0.start = 1'b1; b0.mode = MODE_SCAN_UP; b0.sel = 3'd6;
    tick();
    b0.start = 1'b0; b0.mode = MODE_SCAN_DOWN;
    for (int i = 0; i < 4; i++) begin
      check("up_6_out", 32'(b0.out), 32'h40);
      check("up_6_wrap", 32'(b0.wrap), 32'h0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check("up_7_out", 32'(b0.out), 32'h80);
      check("up_7_wrap", 32'(b0.wrap), 32'h0);
      tick();
    end
    check("up_wrap_out",  32'(b0.out),  32'h01);
    check("up_wrap_pulse", 32'(b0.wrap), 32'h1);
    b0.load = 1'b1; b0.sel = 3'd3;
    tick();
    b0.load = 1'b0;
    check("up_after_wrap", 32'(b0.wrap), 32'h0);
    check("scan_load_ign", 32'(b0.out),  32'h01);

    // stop beats start; OFF from IDLE stays off.
    b0.stop = 1'b1; b0.start = 1'b1; b0.mode = MODE_DIRECT; b0.sel = 3'd4;
    tick();
    b0.stop = 1'b0; b0.start = 1'b0;
    check("stopstart_out",   32'(b0.out),   32'h0);
    check("stopstart_valid", 32'(b0.valid), 32'h0);
    b0.start = 1'b1; b0.mode = MODE_OFF; b0.sel = 3'd3;
    tick();
    b0.start = 1'b0;
    check("off_out",   32'(b0.out),   32'h0);
    check("off_valid", 32'(b0.valid), 32'h0);

    // SCAN_DOWN from 1 with DWELL=1.
    b1.start = 1'b1; b1.mode = MODE_SCAN_DOWN; b1.sel = 3'd1;
    tick();
    b1.start = 1'b0;
    check("dn_0_out", 32'(b1.out), 32'h02); check("dn_0_wrap", 32'(b1.wrap), 32'h0);
    tick();
    check("dn_1_out", 32'(b1.out), 32'h01); check("dn_1_wrap", 32'(b1.wrap), 32'h0);
    tick();
    check("dn_2_out", 32'(b1.out), 32'h80); check("dn_2_wrap", 32'(b1.wrap), 32'h1);
    tick();
    check("dn_3_out", 32'(b1.out), 32'h40); check("dn_3_wrap", 32'(b1.wrap), 32'h0);

    // SEL_W=4 build.
    b2.start = 1'b1; b2.mode = MODE_DIRECT; b2.sel = 4'd15;
    tick();
    b2.start = 1'b0;
    check("w4_direct_out", 32'(b2.out), 32'h8000);
    b2.start = 1'b1; b2.mode = MODE_SCAN_UP; b2.sel = 4'd0;
    tick();
    b2.start = 1'b0;
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 2; j++) begin
        check("w4_scan_out", 32'(b2.out), 32'h1 << i);
        check("w4_scan_idx", 32'(b2.out_idx), 32'(i));
        if (b2.wrap) wraps++;
        tick();
      end
    end
    check("w4_return_out", 32'(b2.out), 32'h0001);
    if (b2.wrap) wraps++;
    check("w4_wrap_count", 32'(wraps), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
